axi_wr_burst_splitter: RTL and testbench

AXI_WR_BURST_SPLITTER -- requirements
Module: axi_wr_burst_splitter

---
 rtl/axi_split_pkg.sv | 28 ++
 rtl/axi_wr_burst_splitter.sv | 174 +++++++++++++++++
 tb/tb_axi_wr_burst_splitter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_split_pkg.sv
// Shared FSM state, burst and response codes for the AXI write burst splitter.
package axi_split_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    BRSP
  } state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Response codes are ordered by severity, so the worst is the numeric max.
  function automatic logic [1:0] resp_max(input logic [1:0] a,
                                          input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_wr_burst_splitter.sv
// Splits upstream AXI write bursts into single-beat downstream writes,
// one outstanding at a time, merging beat responses into one upstream B.
module axi_wr_burst_splitter
  import axi_split_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_ADDR_WIDTH = 31,
  parameter int AXI_TID_WIDTH  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [AXI_TID_WIDTH-1:0]    s_axi_awid,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic [AXI_TID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [AXI_TID_WIDTH-1:0]    m_axi_awid,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [AXI_TID_WIDTH-1:0]    m_axi_bid,
  input  logic [1:0]                  m_axi_bresp
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] ONE = AW'(1);

  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, addr_nxt, step, wmask;
  logic [AXI_TID_WIDTH-1:0] id_q, id_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic [2:0] size_q, size_d;
  logic [1:0] burst_q, burst_d, resp_q, resp_d;
  logic aw_hs, w_hs, b_hs, last_beat;
  logic unused_bid;

  assign unused_bid = ^m_axi_bid;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs = (state_q == DATA) & s_axi_wvalid & m_axi_wready;
  assign b_hs = (state_q == RESP) & m_axi_bvalid;
  assign last_beat = (cnt_q == len_q);

  // WRAP keeps the upper bits and lets the low bits roll over the window.
  assign step = ONE << size_q;
  assign wmask = ((AW'(len_q) + ONE) << size_q) - ONE;

  always_comb begin
    unique case (burst_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_WRAP:  addr_nxt = (addr_q & ~wmask) | ((addr_q + step) & wmask);
      default:     addr_nxt = addr_q + step;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (aw_hs) state_d = ADDR;
      ADDR: if (m_axi_awready) state_d = DATA;
      DATA: if (w_hs) state_d = RESP;
      RESP: if (b_hs) state_d = last_beat ? BRSP : ADDR;
      BRSP: if (s_axi_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_axi_wready  = 1'b0;
    m_axi_bready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (state_q)
      IDLE: s_axi_awready = ~reset;
      ADDR: m_axi_awvalid = 1'b1;
      DATA: begin
        m_axi_wvalid = s_axi_wvalid;
        s_axi_wready = m_axi_wready;
      end
      RESP: m_axi_bready = 1'b1;
      BRSP: s_axi_bvalid = 1'b1;
      default: ;
    endcase
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = id_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = size_q;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = 1'b1;
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = resp_q;

  always_comb begin
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    if (aw_hs) begin
      addr_d  = s_axi_awaddr;
      id_d    = s_axi_awid;
      len_d   = s_axi_awlen;
      size_d  = s_axi_awsize;
      burst_d = s_axi_awburst;
      cnt_d   = 8'd0;
      resp_d  = RESP_OKAY;
    end
    // A misplaced wlast is reported as SLVERR but the burst still runs out.
    if (w_hs && (s_axi_wlast != last_beat))
      resp_d = resp_max(resp_q, RESP_SLVERR);
    if (b_hs) begin
      resp_d = resp_max(resp_q, m_axi_bresp);
      if (!last_beat) begin
        cnt_d  = cnt_q + 8'd1;
        addr_d = addr_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_splitter.sv
// Bench for axi_wr_burst_splitter: directed vector table, reset abort
// sequence and random bursts checked against an arithmetic address model.
module tb_axi_wr_burst_splitter;

  localparam int DW = 32;
  localparam int AW = 31;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset;
  logic s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [IW-1:0] s_axi_awid;
  logic [7:0] s_axi_awlen;
  logic [2:0] s_axi_awsize;
  logic [1:0] s_axi_awburst;
  logic s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic s_axi_wlast;
  logic s_axi_bvalid, s_axi_bready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0] s_axi_bresp;
  logic m_axi_awvalid, m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [IW-1:0] m_axi_awid;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst;
  logic m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_wlast;
  logic m_axi_bvalid, m_axi_bready;
  logic [IW-1:0] m_axi_bid;
  logic [1:0] m_axi_bresp;

  axi_wr_burst_splitter #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .AXI_TID_WIDTH (IW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [1:0] bresp_tab [256];

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    int            len;
    int            size;
    logic [1:0]    bt;
    int            errb;
    int            stl;
    logic [7:0]    resps;
    logic [1:0]    xresp;
    logic [AW-1:0] xlast;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat address from the burst rules, computed with plain arithmetic.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a,
      input int len, input int size, input logic [1:0] bt, input int i);
    longint unsigned base, bytes, total, lower;
    base  = 64'(a);
    bytes = 64'd1 << size;
    total = bytes * 64'(len + 1);
    if (bt == 2'b00) return a;
    if (bt == 2'b10) begin
      lower = base - (base % total);
      return AW'(lower + ((base - lower + bytes * 64'(i)) % total));
    end
    return AW'(base + bytes * 64'(i));
  endfunction

  function automatic logic [1:0] exp_resp(input int len, input int errb);
    logic [1:0] x;
    x = 2'b00;
    for (int i = 0; i <= len; i++)
      if (bresp_tab[i] > x) x = bresp_tab[i];
    if (errb >= 0 && x != 2'b11) x = 2'b10;
    return x;
  endfunction

  task automatic quiet_chk(input string name);
    chk(name, {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
               s_axi_wready, s_axi_bvalid, s_axi_awready}, 0);
  endtask

  task automatic run_burst(input logic [AW-1:0] a, input logic [IW-1:0] id,
      input int len, input int size, input logic [1:0] bt, input int errb,
      input int stl, input logic [1:0] xresp, input logic [AW-1:0] xlast,
      input int abort_beat);
    logic [AW-1:0] ea;
    logic [DW-1:0] wd;
    logic [DW/8-1:0] ws;
    chk("aw_ready_idle", s_axi_awready, 1);
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = a;
    s_axi_awid    = id;
    s_axi_awlen   = 8'(len);
    s_axi_awsize  = 3'(size);
    s_axi_awburst = bt;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    #1;
    for (int i = 0; i <= len; i++) begin
      ea = exp_addr(a, len, size, bt, i);
      chk("aw_valid", m_axi_awvalid, 1);
      chk("busy_flags", {s_axi_bvalid, s_axi_awready}, 0);
      if (i == abort_beat) begin
        reset = 1'b1;
        #1;
        quiet_chk("rst_mid_burst");
        return;
      end
      for (int k = 0; k < stl; k++) begin
        @(posedge clk); #1;
        chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, ea});
      end
      chk("aw_addr", m_axi_awaddr, ea);
      if (i == len) chk("aw_addr_last", m_axi_awaddr, xlast);
      chk("aw_fields", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst},
          {id, 8'd0, 3'(size), 2'b01});
      m_axi_awready = 1'b1;
      @(posedge clk); #1;
      m_axi_awready = 1'b0;
      wd = $urandom;
      ws = 4'($urandom);
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wd;
      s_axi_wstrb  = ws;
      s_axi_wlast  = (i == len) ^ (i == errb);
      #1;
      chk("aw_dropped", m_axi_awvalid, 0);
      for (int k = 0; k < stl; k++) begin
        @(posedge clk); #1;
        chk("w_hold", {m_axi_wvalid, s_axi_wready, m_axi_wdata},
            {1'b1, 1'b0, wd});
      end
      m_axi_wready = 1'b1;
      #1;
      chk("w_pass", {m_axi_wvalid, s_axi_wready, m_axi_wlast, m_axi_wdata,
                     m_axi_wstrb}, {3'b111, wd, ws});
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0;
      m_axi_wready = 1'b0;
      s_axi_wlast  = 1'b0;
      #1;
      chk("b_ready_dn", m_axi_bready, 1);
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = bresp_tab[i];
      m_axi_bid    = id;
      @(posedge clk); #1;
      m_axi_bvalid = 1'b0;
      #1;
    end
    chk("b_valid_up", s_axi_bvalid, 1);
    chk("b_payload", {s_axi_bid, s_axi_bresp}, {id, xresp});
    for (int k = 0; k < stl; k++) begin
      @(posedge clk); #1;
      chk("b_hold", {s_axi_bvalid, s_axi_bid, s_axi_bresp}, {1'b1, id, xresp});
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    #1;
    chk("back_idle", {s_axi_bvalid, s_axi_awready}, 2'b01);
  endtask

  vec_t vecs [11];

  initial begin
    int len, size, errb, stl, r;
    logic [1:0] bt;
    logic [AW-1:0] a;

    vecs[0]  = '{31'h100,     2'd1, 0, 6, 2'b01, -1, 0, 8'h00, 2'd0, 31'h100};
    vecs[1]  = '{31'h1000,    2'd2, 3, 6, 2'b01, -1, 0, 8'h00, 2'd0, 31'h10C0};
    vecs[2]  = '{31'h1040,    2'd3, 3, 6, 2'b10, -1, 0, 8'h00, 2'd0, 31'h1000};
    vecs[3]  = '{31'h2000,    2'd0, 2, 2, 2'b01, -1, 0, 8'h08, 2'd2, 31'h2008};
    vecs[4]  = '{31'h3000,    2'd1, 2, 2, 2'b01,  0, 0, 8'h00, 2'd2, 31'h3008};
    vecs[5]  = '{31'h4000,    2'd1, 1, 3, 2'b01, -1, 5, 8'h00, 2'd0, 31'h4008};
    vecs[6]  = '{31'h5000,    2'd2, 2, 2, 2'b00, -1, 1, 8'h00, 2'd0, 31'h5000};
    vecs[7]  = '{31'h6000,    2'd3, 1, 4, 2'b11, -1, 0, 8'h00, 2'd0, 31'h6010};
    vecs[8]  = '{31'h7000,    2'd0, 1, 3, 2'b01,  1, 0, 8'h03, 2'd3, 31'h7008};
    vecs[9]  = '{31'h7FFFFFC0, 2'd1, 1, 6, 2'b01, -1, 0, 8'h00, 2'd0, 31'h0};
    vecs[10] = '{31'h8014,    2'd2, 7, 2, 2'b10, -1, 0, 8'h00, 2'd0, 31'h8010};

    reset = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awid = 0; s_axi_awlen = 0;
    s_axi_awsize = 0; s_axi_awburst = 0; s_axi_wvalid = 0; s_axi_wdata = 0;
    s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_bready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bid = 0;
    m_axi_bresp = 0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    quiet_chk("reset_outputs");
    reset = 1'b0;
    #1;
    chk("awready_after_rst", s_axi_awready, 1);
    chk("reset_fields", {m_axi_awaddr, m_axi_awid, m_axi_awsize,
                         s_axi_bid, s_axi_bresp}, 0);

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 256; i++) bresp_tab[i] = 2'b00;
      for (int i = 0; i < 4; i++) bresp_tab[i] = vecs[v].resps[2*i +: 2];
      run_burst(vecs[v].addr, vecs[v].id, vecs[v].len, vecs[v].size,
                vecs[v].bt, vecs[v].errb, vecs[v].stl, vecs[v].xresp,
                vecs[v].xlast, -1);
    end

    for (int i = 0; i < 256; i++) bresp_tab[i] = 2'b00;
    run_burst(31'h9000, 2'd1, 3, 6, 2'b01, -1, 0, 2'd0, 31'h90C0, 2);
    repeat (2) @(posedge clk);
    #1;
    quiet_chk("rst_held");
    reset = 1'b0;
    #1;
    chk("awready_after_abort", s_axi_awready, 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("no_b_after_abort", {s_axi_bvalid, m_axi_awvalid, s_axi_awready},
          3'b001);
    end
    run_burst(31'hA000, 2'd2, 1, 2, 2'b01, -1, 0, 2'd0, 31'hA004, -1);

    for (int n = 0; n < 25; n++) begin
      bt = 2'($urandom_range(0, 3));
      size = $urandom_range(0, 6);
      if (bt == 2'b10) len = (2 << $urandom_range(0, 3)) - 1;
      else len = $urandom_range(0, 7);
      a = AW'($urandom);
      if (bt == 2'b10) a = a & ~((AW'(1) << size) - AW'(1));
      errb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      stl = $urandom_range(0, 2);
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 9);
        bresp_tab[i] = (r < 7) ? 2'b00 : ((r < 9) ? 2'b10 : 2'b11);
      end
      run_burst(a, IW'($urandom), len, size, bt, errb, stl,
                exp_resp(len, errb), exp_addr(a, len, size, bt, len), -1);
    end

    for (int i = 0; i < 256; i++) bresp_tab[i] = 2'b00;
    bresp_tab[200] = 2'b10;
    run_burst(31'h10000, 2'd3, 255, 2, 2'b01, -1, 0, exp_resp(255, -1),
              exp_addr(31'h10000, 255, 2, 2'b01, 255), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
